// File: rtl/instr_issue_queue.sv
// instr_issue_queue: FIFO buffer between the instruction loader and the
// processor. It issues at most one instruction per clock, discards words
// with invalid opcodes, and inserts a one-cycle NOP bubble when the head
// reads the register written by the instruction issued just before it.
module instr_issue_queue #(
  parameter int unsigned DEPTH     = 8,
  parameter bit          INTERLOCK = 1'b1,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [31:0]              in_instr,
  output logic                     in_ready,
  output logic [31:0]              issue_instr,
  output logic                     issue_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [15:0]              drop_count,
  output logic [15:0]              stall_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // Storage and pointer state.
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Issue stage and interlock tracking.
  logic [31:0]   issue_instr_q, issue_instr_d;
  logic          issue_valid_q, issue_valid_d;
  logic [4:0]    last_dest_q, last_dest_d;
  logic          last_dest_valid_q, last_dest_valid_d;

  // Statistics.
  logic [15:0]   drop_count_q, drop_count_d;
  logic [15:0]   stall_count_q, stall_count_d;

  // Head entry decode.
  logic [31:0]   head;
  logic [5:0]    head_op;
  logic [4:0]    head_src_a;
  logic [4:0]    head_src_b;
  logic [4:0]    head_dest;
  logic          head_op_valid;
  logic          head_reads_b;
  logic          hazard;
  logic          push;
  logic          pop;

  function automatic logic op_is_valid(input logic [5:0] op);
    case (op)
      6'h01, 6'h06, 6'h0D, 6'h08, 6'h07, 6'h04,
      6'h0B, 6'h0F, 6'h03, 6'h05, 6'h02: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

  // Unary ops only read source A, so source B must not raise a hazard for them.
  function automatic logic op_reads_b(input logic [5:0] op);
    case (op)
      6'h0D, 6'h08, 6'h0F: return 1'b0;
      default:             return 1'b1;
    endcase
  endfunction

  assign head          = mem_q[rd_ptr_q];
  assign head_op       = head[5:0];
  assign head_src_a    = head[10:6];
  assign head_src_b    = head[15:11];
  assign head_dest     = head[20:16];
  assign head_op_valid = op_is_valid(head_op);
  assign head_reads_b  = op_reads_b(head_op);

  assign hazard = INTERLOCK && last_dest_valid_q &&
                  ((head_src_a == last_dest_q) ||
                   (head_reads_b && (head_src_b == last_dest_q)));

  // Ready depends only on registered occupancy, so a full queue never
  // accepts even if the head leaves in the same cycle.
  assign in_ready = (count_q != FULL_COUNT) && rst_n;
  assign push     = in_valid && in_ready && !flush;

  // Issue decision on the head entry plus pointer, count and statistics update.
  always_comb begin
    wr_ptr_d          = wr_ptr_q;
    rd_ptr_d          = rd_ptr_q;
    count_d           = count_q;
    issue_instr_d     = NOP_WORD;
    issue_valid_d     = 1'b0;
    last_dest_d       = last_dest_q;
    last_dest_valid_d = last_dest_valid_q;
    drop_count_d      = drop_count_q;
    stall_count_d     = stall_count_q;
    pop               = 1'b0;

    if (flush) begin
      wr_ptr_d          = '0;
      rd_ptr_d          = '0;
      count_d           = '0;
      last_dest_valid_d = 1'b0;
    end else begin
      if (count_q == '0) begin
        last_dest_valid_d = 1'b0;
      end else if (!head_op_valid) begin
        pop               = 1'b1;
        last_dest_valid_d = 1'b0;
        if (drop_count_q != 16'hFFFF) begin
          drop_count_d = drop_count_q + 16'd1;
        end
      end else if (hazard) begin
        last_dest_valid_d = 1'b0;
        if (stall_count_q != 16'hFFFF) begin
          stall_count_d = stall_count_q + 16'd1;
        end
      end else begin
        pop               = 1'b1;
        issue_instr_d     = head;
        issue_valid_d     = 1'b1;
        last_dest_d       = head_dest;
        last_dest_valid_d = 1'b1;
      end

      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // State registers; reset empties the queue and restores the NOP output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      count_q           <= '0;
      issue_instr_q     <= NOP_WORD;
      issue_valid_q     <= 1'b0;
      last_dest_q       <= '0;
      last_dest_valid_q <= 1'b0;
      drop_count_q      <= '0;
      stall_count_q     <= '0;
    end else begin
      wr_ptr_q          <= wr_ptr_d;
      rd_ptr_q          <= rd_ptr_d;
      count_q           <= count_d;
      issue_instr_q     <= issue_instr_d;
      issue_valid_q     <= issue_valid_d;
      last_dest_q       <= last_dest_d;
      last_dest_valid_q <= last_dest_valid_d;
      drop_count_q      <= drop_count_d;
      stall_count_q     <= stall_count_d;
    end
  end

  // Entry storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_instr;
    end
  end

  assign issue_instr = issue_instr_q;
  assign issue_valid = issue_valid_q;
  assign count       = count_q;
  assign full        = (count_q == FULL_COUNT);
  assign empty       = (count_q == '0);
  assign drop_count  = drop_count_q;
  assign stall_count = stall_count_q;

endmodule
